// File: rtl/gpio_multi.sv
// Memory-mapped GPIO with NCH channels of W bits: synchronised inputs, registered outputs,
// rising-edge interrupt status (RW1C) and per-bit interrupt enables.
module gpio_multi #(
  parameter int unsigned W    = 32,
  parameter int unsigned NCH  = 2,
  parameter int unsigned SYNC = 2,
  parameter int unsigned AW   = $clog2(NCH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     A,
  input  logic              WE,
  input  logic [W-1:0]      WD,
  output logic [W-1:0]      RD,
  input  logic [NCH*W-1:0]  gpI,
  output logic [NCH*W-1:0]  gpO,
  output logic              irq
);

  localparam int unsigned NW = NCH * W;

  typedef enum logic [1:0] {
    RegIn  = 2'd0,
    RegOut = 2'd1,
    RegIe  = 2'd2,
    RegIsr = 2'd3
  } reg_e;

  logic [NW-1:0]  sync_q [SYNC];
  logic [NW-1:0]  sync_d [SYNC];
  logic [NW-1:0]  prev_q, prev_d;
  logic [NW-1:0]  out_q, out_d;
  logic [NW-1:0]  ie_q, ie_d;
  logic [NW-1:0]  isr_q, isr_d;
  logic [NW-1:0]  in_val, rise;
  logic [AW-1:0]  ch_idx;
  logic [NCH-1:0] ch_sel;
  reg_e           reg_sel;

  assign ch_idx  = A >> 2;
  assign reg_sel = reg_e'(A[1:0]);
  assign in_val  = sync_q[SYNC-1];
  assign rise    = in_val & ~prev_q;

  // Out-of-range channel indices select nothing, so writes drop and RD stays 0.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      ch_sel[c] = (ch_idx == AW'(c));
    end
  end

  always_comb begin
    sync_d[0] = gpI;
    for (int s = 1; s < SYNC; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d = in_val;
    out_d  = out_q;
    ie_d   = ie_q;
    isr_d  = isr_q;
    for (int c = 0; c < NCH; c++) begin
      if (WE && ch_sel[c]) begin
        case (reg_sel)
          RegOut:  out_d[c*W +: W] = WD;
          RegIe:   ie_d[c*W +: W]  = WD;
          RegIsr:  isr_d[c*W +: W] = isr_q[c*W +: W] & ~WD;
          default: ;
        endcase
      end
    end
    // Applied after the W1C so a coincident new edge keeps the bit set.
    isr_d = isr_d | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
      out_q  <= '0;
      ie_q   <= '0;
      isr_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      out_q  <= out_d;
      ie_q   <= ie_d;
      isr_q  <= isr_d;
    end
  end

  always_comb begin
    RD = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_sel[c]) begin
        case (reg_sel)
          RegIn:   RD = in_val[c*W +: W];
          RegOut:  RD = out_q[c*W +: W];
          RegIe:   RD = ie_q[c*W +: W];
          RegIsr:  RD = isr_q[c*W +: W];
          default: RD = '0;
        endcase
      end
    end
  end

  assign gpO = out_q;
  assign irq = |(isr_q & ie_q);

endmodule

// File: tb/tb_gpio_multi.sv
// Bench for gpio_multi: directed literal checks plus randomized traffic compared every cycle
// against a sample-history reference model.
module tb_gpio_multi;

  localparam int unsigned W    = 32;
  localparam int unsigned NCH  = 3;
  localparam int unsigned SYNC = 2;
  localparam int unsigned AW   = 4;
  localparam int unsigned NW   = NCH * W;

  logic          clk;
  logic          rst;
  logic [AW-1:0] A;
  logic          WE;
  logic [W-1:0]  WD;
  logic [W-1:0]  RD;
  logic [NW-1:0] gpI;
  logic [NW-1:0] gpO;
  logic          irq;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_multi #(
    .W    (W),
    .NCH  (NCH),
    .SYNC (SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .WE  (WE),
    .WD  (WD),
    .RD  (RD),
    .gpI (gpI),
    .gpO (gpO),
    .irq (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: hist[0] is the gpI sample from the latest edge; IN is the sample taken
  // SYNC-1 edges earlier and the previous IN is one sample older still.
  logic [NW-1:0] hist [SYNC+1];
  logic [NW-1:0] m_out, m_ie, m_isr, m_rise;
  bit            m_valid = 1'b0;
  int            m_ch;

  always @(posedge clk) begin
    if (rst) begin
      m_out = '0;
      m_ie  = '0;
      m_isr = '0;
      for (int i = 0; i <= SYNC; i++) hist[i] = '0;
      m_valid = 1'b1;
    end else begin
      m_rise = hist[SYNC-1] & ~hist[SYNC];
      m_ch   = int'(A >> 2);
      if (WE && m_ch < NCH) begin
        case (A[1:0])
          2'd1:    m_out[m_ch*W +: W] = WD;
          2'd2:    m_ie[m_ch*W +: W]  = WD;
          2'd3:    m_isr[m_ch*W +: W] = m_isr[m_ch*W +: W] & ~WD;
          default: ;
        endcase
      end
      m_isr = m_isr | m_rise;
      for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = gpI;
    end
  end

  function automatic logic [W-1:0] model_rd(input logic [AW-1:0] a);
    int ch;
    ch = int'(a >> 2);
    if (ch >= NCH) return '0;
    case (a[1:0])
      2'd0:    return hist[SYNC-1][ch*W +: W];
      2'd1:    return m_out[ch*W +: W];
      2'd2:    return m_ie[ch*W +: W];
      default: return m_isr[ch*W +: W];
    endcase
  endfunction

  task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_gpo", gpO, m_out);
      check("model_irq", NW'(irq), NW'(|(m_isr & m_ie)));
      check("model_rd", NW'(RD), NW'(model_rd(A)));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    A  = a;
    WD = d;
    WE = 1'b1;
    step();
    WE = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [AW-1:0] a, input logic [W-1:0] exp);
    A  = a;
    WE = 1'b0;
    #1;
    check(name, NW'(RD), NW'(exp));
  endtask

  initial begin
    rst = 1'b1;
    WE  = 1'b0;
    A   = '0;
    WD  = '0;
    gpI = '1;
    step();
    step();
    check("rst_gpo", gpO, '0);
    check("rst_irq", NW'(irq), '0);
    for (int c = 0; c < NCH; c++) begin
      for (int r = 1; r < 4; r++) begin
        rd_check("rst_rd", AW'(c * 4 + r), '0);
      end
    end
    rst = 1'b0;
    gpI = '0;
    step();

    wr(4'h5, 32'hDEADBEEF);
    check("out_ch1", NW'(gpO[63:32]), NW'(32'hDEADBEEF));
    check("out_ch0", NW'(gpO[31:0]), '0);
    rd_check("out_rd", 4'h5, 32'hDEADBEEF);

    gpI[31:0] = 32'h5;
    step();
    rd_check("in_k", 4'h0, 32'h0);
    step();
    rd_check("in_k1", 4'h0, 32'h5);
    rd_check("isr_k1", 4'h3, 32'h0);
    step();
    rd_check("isr_k2", 4'h3, 32'h5);
    check("irq_ie0", NW'(irq), '0);

    wr(4'h2, 32'h1);
    check("irq_en", NW'(irq), NW'(1'b1));
    wr(4'h3, 32'h1);
    rd_check("isr_w1c", 4'h3, 32'h4);
    check("irq_w1c", NW'(irq), '0);
    wr(4'h2, 32'h4);
    check("irq_ie4", NW'(irq), NW'(1'b1));

    gpI[31:0] = 32'hD;
    step();
    step();
    wr(4'h3, 32'hC);
    rd_check("isr_race", 4'h3, 32'h8);
    check("irq_race", NW'(irq), '0);
    gpI[31:0] = 32'h5;
    step();
    step();
    step();
    rd_check("isr_fall", 4'h3, 32'h8);
    wr(4'h3, 32'h8);
    rd_check("isr_clr", 4'h3, 32'h0);

    wr(4'hD, 32'hFFFFFFFF);
    wr(4'hE, 32'hFFFFFFFF);
    wr(4'hF, 32'hFFFFFFFF);
    check("oob_gpo", gpO, {32'h0, 32'hDEADBEEF, 32'h0});
    check("oob_irq", NW'(irq), '0);
    for (int r = 0; r < 4; r++) begin
      rd_check("oob_rd", AW'(12 + r), '0);
    end

    wr(4'hA, 32'h10);
    gpI[95:64] = 32'hF0;
    step();
    step();
    step();
    rd_check("isr_ch2", 4'hB, 32'hF0);
    check("irq_ch2", NW'(irq), NW'(1'b1));
    rst = 1'b1;
    step();
    rd_check("rst_isr", 4'hB, 32'h0);
    rd_check("rst_out", 4'h5, 32'h0);
    check("rst2_gpo", gpO, '0);
    check("rst2_irq", NW'(irq), '0);
    rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      WE  = $urandom_range(0, 1) == 1;
      A   = AW'($urandom_range(0, 15));
      WD  = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        gpI = gpI ^ ({$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom});
      end
      step();
    end
    rst = 1'b0;
    WE  = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
